// File: rtl/rom_mult_pipe.sv
// rom_mult_pipe: pipelined ROM-operand multiply / multiply-accumulate with an in-order result log.
//
// Two addresses index two fixed operand ROMs (ROM1[i] = i+1, ROM2[i] = 2i+1, both mod 2^DATA_W).
// The operands are multiplied and, in mode 1, added to an accumulator. Each result is driven
// on result/result_valid and logged into a small result RAM that is drained in order by rd_en.
//
// Pipeline: S1 ROM operands -> S2 product -> S3 staged product -> result register + RAM write.
// Accept at edge T gives result_valid in the cycle after edge T+3.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready request handshake; in_ready depends on count only
//   rom_addr1/2, mode operands and op select (0 = multiply, 1 = multiply-accumulate)
//   clr_acc           synchronous accumulator clear, acts on the op currently in S3
//   result(_valid)    last result and its one-cycle strobe
//   rd_en             pop request; rd_data/rd_valid appear one cycle after the sampling edge
//   count             entries stored in the RAM plus entries in flight
//
// Build option: define ROM_MULT_SATURATE_EN to saturate mode-1 accumulation instead of wrapping.

`timescale 1ns/1ps

module rom_mult_pipe #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned RES_W  = 8,
    parameter int unsigned RAM_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rom_addr1,
    input  logic [ADDR_W-1:0] rom_addr2,
    input  logic              mode,
    input  logic              clr_acc,
    output logic [RES_W-1:0]  result,
    output logic              result_valid,
    input  logic              rd_en,
    output logic [RES_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic [RAM_AW:0]   count
);

    localparam int unsigned   RamDepth = 2 ** RAM_AW;
    localparam logic [RAM_AW:0] CntFull = (RAM_AW + 1)'(RamDepth);

    function automatic logic [DATA_W-1:0] rom1(input logic [ADDR_W-1:0] a);
        return DATA_W'(32'(a) + 32'd1);
    endfunction

    function automatic logic [DATA_W-1:0] rom2(input logic [ADDR_W-1:0] a);
        return DATA_W'(32'(a) * 32'd2 + 32'd1);
    endfunction

    // Pipeline registers
    logic                s1_valid_q, s2_valid_q, s3_valid_q;
    logic                s1_mode_q, s2_mode_q, s3_mode_q;
    logic [DATA_W-1:0]   s1_op1_q, s1_op2_q;
    logic [RES_W-1:0]    s2_prod_q, s3_prod_q;
    logic [2*DATA_W-1:0] prod;

    // Result / accumulator
    logic [RES_W-1:0]    acc_q, acc_d, acc_base, mac_res, res_d, result_q;
    logic                result_valid_q;

    // Result log
    logic [RES_W-1:0]    ram [RamDepth];
    logic [RAM_AW-1:0]   wr_ptr_q, rd_ptr_q, pop_addr_q;
    logic [RAM_AW:0]     count_q, count_d, stored_q, stored_d;
    logic                pop_pend_q, rd_valid_q;
    logic [RES_W-1:0]    rd_data_q;

    logic                accept, pop;

    assign in_ready = (count_q < CntFull);
    assign accept   = in_valid && in_ready;
    // Only entries already written can be popped, so a same-cycle write is never read.
    assign pop      = rd_en && (stored_q != '0);

    assign prod = (2 * DATA_W)'(s1_op1_q) * (2 * DATA_W)'(s1_op2_q);

    always_comb begin
        acc_base = clr_acc ? '0 : acc_q;
`ifdef ROM_MULT_SATURATE_EN
        begin
            logic [RES_W:0] sum_w;
            sum_w   = {1'b0, acc_base} + {1'b0, s3_prod_q};
            mac_res = sum_w[RES_W] ? '1 : sum_w[RES_W-1:0];
        end
`else
        mac_res = acc_base + s3_prod_q;
`endif
        res_d = s3_mode_q ? mac_res : s3_prod_q;

        acc_d = acc_q;
        if (s3_valid_q && s3_mode_q) begin
            acc_d = mac_res;
        end else if (clr_acc) begin
            acc_d = '0;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        stored_d = stored_q;
        unique case ({s3_valid_q, pop})
            2'b10:   stored_d = stored_q + 1'b1;
            2'b01:   stored_d = stored_q - 1'b1;
            default: stored_d = stored_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q     <= 1'b0;
            s2_valid_q     <= 1'b0;
            s3_valid_q     <= 1'b0;
            s1_mode_q      <= 1'b0;
            s2_mode_q      <= 1'b0;
            s3_mode_q      <= 1'b0;
            s1_op1_q       <= '0;
            s1_op2_q       <= '0;
            s2_prod_q      <= '0;
            s3_prod_q      <= '0;
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            pop_addr_q     <= '0;
            count_q        <= '0;
            stored_q       <= '0;
            pop_pend_q     <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            s1_valid_q <= accept;
            s1_mode_q  <= mode;
            s1_op1_q   <= rom1(rom_addr1);
            s1_op2_q   <= rom2(rom_addr2);

            s2_valid_q <= s1_valid_q;
            s2_mode_q  <= s1_mode_q;
            s2_prod_q  <= RES_W'(prod);

            s3_valid_q <= s2_valid_q;
            s3_mode_q  <= s2_mode_q;
            s3_prod_q  <= s2_prod_q;

            acc_q          <= acc_d;
            result_valid_q <= s3_valid_q;
            if (s3_valid_q) begin
                result_q <= res_d;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end

            count_q  <= count_d;
            stored_q <= stored_d;

            // Pop: pointer advances at the sampling edge, the RAM read lands one edge later.
            pop_pend_q <= pop;
            if (pop) begin
                pop_addr_q <= rd_ptr_q;
                rd_ptr_q   <= rd_ptr_q + 1'b1;
            end
            rd_valid_q <= pop_pend_q;
            if (pop_pend_q) begin
                rd_data_q <= ram[pop_addr_q];
            end
        end
    end

    // RAM contents are not reset.
    always_ff @(posedge clk) begin
        if (s3_valid_q) begin
            ram[wr_ptr_q] <= res_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;

endmodule

// File: tb/tb_rom_mult_pipe.sv
// Directed bench for rom_mult_pipe: table of operations with hand-computed results, plus
// hand-written sequences for latency, accumulator clear in S3, full, empty/simultaneous
// pop and mid-operation reset.

`timescale 1ns/1ps

module tb_rom_mult_pipe;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned RES_W  = 8;
    localparam int unsigned RAM_AW = 3;

`ifdef ROM_MULT_SATURATE_EN
    localparam logic [RES_W-1:0] Sat3 = 8'hFF;
`else
    localparam logic [RES_W-1:0] Sat3 = 8'h68;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] rom_addr1 = '0;
    logic [ADDR_W-1:0] rom_addr2 = '0;
    logic              mode = 1'b0;
    logic              clr_acc = 1'b0;
    logic [RES_W-1:0]  result;
    logic              result_valid;
    logic              rd_en = 1'b0;
    logic [RES_W-1:0]  rd_data;
    logic              rd_valid;
    logic [RAM_AW:0]   count;

    rom_mult_pipe #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .RES_W (RES_W),
        .RAM_AW(RAM_AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rom_addr1   (rom_addr1),
        .rom_addr2   (rom_addr2),
        .mode        (mode),
        .clr_acc     (clr_acc),
        .result      (result),
        .result_valid(result_valid),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .count       (count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [RES_W-1:0] exp_q[$];  // next values on the result strobe
    logic [RES_W-1:0] ram_q[$];  // next values from pops

    typedef struct {
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
        logic              mode;
        logic              clr;   // pulse clr_acc on an idle pipeline first
        logic              last;  // end of group: let results land, then drain
        logic [RES_W-1:0]  exp;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl[NV];

    logic [RES_W-1:0] full_exp[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Every result strobe is matched against the expected queue.
    always @(negedge clk) begin
        if (reset && result_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious result_valid", 32'(result_valid), 32'd0);
            end else begin
                check("result", 32'(result), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one operation for one edge; assumes in_ready is high.
    task automatic issue(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                         input logic m, input logic [RES_W-1:0] e);
        rom_addr1 = a1;
        rom_addr2 = a2;
        mode      = m;
        in_valid  = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        ram_q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic pop_check(input string name);
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, " rd_valid"}, 32'(rd_valid), 32'd1);
        check({name, " rd_data"}, 32'(rd_data), 32'(ram_q.pop_front()));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        while (ram_q.size() > 0) pop_check(name);
        check({name, " count drained"}, 32'(count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3'd3, 3'd4, 1'b1, 1'b1, 1'b0, 8'h24};
        tbl[1] = '{3'd5, 3'd6, 1'b1, 1'b0, 1'b1, 8'h72};
        tbl[2] = '{3'd7, 3'd7, 1'b1, 1'b1, 1'b0, 8'h78};
        tbl[3] = '{3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 8'hF0};
        tbl[4] = '{3'd7, 3'd7, 1'b1, 1'b0, 1'b1, Sat3};
        tbl[5] = '{3'd3, 3'd4, 1'b1, 1'b1, 1'b0, 8'h24};
        tbl[6] = '{3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 8'h0A};
        tbl[7] = '{3'd5, 3'd6, 1'b1, 1'b0, 1'b0, 8'h72};
        tbl[8] = '{3'd2, 3'd5, 1'b0, 1'b0, 1'b0, 8'h21};
        tbl[9] = '{3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h73};
        full_exp = '{8'd1, 8'd6, 8'd15, 8'd28, 8'd45, 8'd66, 8'd91, 8'd120};

        // Reset values
        cyc(2);
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset result", 32'(result), 32'd0);
        check("reset result_valid", 32'(result_valid), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset count", 32'(count), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        cyc(1);

        // Multiply with latency and strobe width
        issue(3'd1, 3'd2, 1'b0, 8'h0A);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("latency early strobe", 32'(result_valid), 32'd0);
        end
        @(negedge clk);
        check("latency strobe", 32'(result_valid), 32'd1);
        @(negedge clk);
        check("strobe width", 32'(result_valid), 32'd0);
        @(posedge clk);
        #1;
        check("count before pop", 32'(count), 32'd1);
        drain("multiply pop");

        // Table: back-to-back groups, drained in order after each group
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].clr) begin
                clr_acc = 1'b1;
                cyc(1);
                clr_acc = 1'b0;
            end
            issue(tbl[i].a1, tbl[i].a2, tbl[i].mode, tbl[i].exp);
            if (tbl[i].last) begin
                cyc(6);
                check("table results outstanding", 32'(exp_q.size()), 32'd0);
                drain("table drain");
            end
        end

        // clr_acc while a mode-1 op sits in S3 (acc is 0x73 here)
        issue(3'd1, 3'd2, 1'b1, 8'h0A);
        issue(3'd1, 3'd2, 1'b1, 8'h14);
        @(posedge clk);
        #1 clr_acc = 1'b1;
        @(posedge clk);
        #1 clr_acc = 1'b0;
        cyc(5);
        check("s3 clr results outstanding", 32'(exp_q.size()), 32'd0);
        drain("s3 clr drain");

        // Full: eight accepts, further requests ignored, one pop reopens
        for (int i = 0; i < 8; i++) issue(3'(i), 3'(i), 1'b0, full_exp[i]);
        check("full count", 32'(count), 32'd8);
        check("full in_ready", 32'(in_ready), 32'd0);
        rom_addr1 = 3'd0;
        rom_addr2 = 3'd0;
        in_valid  = 1'b1;
        cyc(6);
        in_valid = 1'b0;
        check("full ignored count", 32'(count), 32'd8);
        check("full ignored in_ready", 32'(in_ready), 32'd0);
        check("full results outstanding", 32'(exp_q.size()), 32'd0);
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        check("reopen in_ready", 32'(in_ready), 32'd1);
        check("reopen count", 32'(count), 32'd7);
        @(posedge clk);
        @(negedge clk);
        check("reopen rd_valid", 32'(rd_valid), 32'd1);
        check("reopen rd_data", 32'(rd_data), 32'(ram_q.pop_front()));
        @(posedge clk);
        #1;
        drain("full drain");

        // Pop when empty
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        @(negedge clk);
        check("empty rd_valid 1", 32'(rd_valid), 32'd0);
        @(negedge clk);
        check("empty rd_valid 2", 32'(rd_valid), 32'd0);
        check("empty count", 32'(count), 32'd0);
        @(posedge clk);
        #1;

        // Accept and pop in the same cycle
        issue(3'd2, 3'd5, 1'b0, 8'h21);
        cyc(5);
        rom_addr1 = 3'd6;
        rom_addr2 = 3'd3;
        mode      = 1'b0;
        in_valid  = 1'b1;
        rd_en     = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        rd_en = 1'b0;
        check("simul count", 32'(count), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("simul rd_valid", 32'(rd_valid), 32'd1);
        check("simul rd_data", 32'(rd_data), 32'(ram_q.pop_front()));
        exp_q.push_back(8'h31);
        ram_q.push_back(8'h31);
        cyc(5);
        drain("simul drain");

        // Reset one cycle after an accept
        rom_addr1 = 3'd3;
        rom_addr2 = 3'd4;
        mode      = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("in-reset result_valid", 32'(result_valid), 32'd0);
            check("in-reset count", 32'(count), 32'd0);
            check("in-reset in_ready", 32'(in_ready), 32'd1);
            check("in-reset result", 32'(result), 32'd0);
            check("in-reset rd_valid", 32'(rd_valid), 32'd0);
            check("in-reset rd_data", 32'(rd_data), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post-reset result_valid", 32'(result_valid), 32'd0);
            check("post-reset count", 32'(count), 32'd0);
        end
        @(posedge clk);
        #1;
        // Accumulator was cleared by reset (it held 0x14 before)
        issue(3'd1, 3'd2, 1'b1, 8'h0A);
        cyc(5);
        check("post-reset results outstanding", 32'(exp_q.size()), 32'd0);
        drain("post-reset drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rom_mult_pipe.md
# rom_mult_pipe

Parametrised, pipelined successor to the ROM-operand multiplier datapath: two address inputs index two constant operand ROMs, the operands are multiplied (optionally accumulated), and every result is both presented on `result` and logged into an internal result RAM. The RAM is drained in order through a pop port. The block sits between the address sequencer and the downstream result consumer and accepts one operation per cycle under a valid/ready handshake.

## Interface
- `DATA_W`, 4: operand width (ROM word width).
- `ADDR_W`, 3: ROM address width; each ROM has 2^ADDR_W words.
- `RES_W`, 8: result/accumulator width; must be ≥ 2*DATA_W.
- `RAM_AW`, 3: result RAM address width; depth = 2^RAM_AW.

- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: operation request.
- `in_ready`, out, 1: block can accept.
- `rom_addr1`, in, ADDR_W: operand-1 ROM address.
- `rom_addr2`, in, ADDR_W: operand-2 ROM address.
- `mode`, in, 1: 0 = multiply, 1 = multiply-accumulate; sampled with the request.
- `clr_acc`, in, 1: synchronous accumulator clear.
- `result`, out, RES_W: last computed result.
- `result_valid`, out, 1: one-cycle strobe per result.
- `rd_en`, in, 1: pop one logged result.
- `rd_data`, out, RES_W: popped result.
- `rd_valid`, out, 1: `rd_data` valid strobe.
- `count`, out, RAM_AW+1: entries stored plus entries in flight.

## Operation
- ROM contents (fixed): ROM1[i] = (i+1) mod 2^DATA_W; ROM2[i] = (2i+1) mod 2^DATA_W.
- Accept when `in_valid && in_ready`; `in_ready` = (`count` < 2^RAM_AW). `count` increments on accept, decrements on an effective pop; both in one cycle leaves it unchanged.
- Pipeline: S1 registers ROM1[addr1], ROM2[addr2], mode; S2 registers product (zero-extended to RES_W); S3 computes the result, writes it to the RAM at `wr_ptr`, drives `result`/`result_valid`.
- mode 0: result = product; accumulator unchanged.
- mode 1: result = acc + product, truncated to RES_W (wraps); acc <= result.
- `clr_acc` at S3 of a mode-1 operation: the addition uses 0, so result = product and acc <= product. `clr_acc` with no mode-1 op in S3: acc <= 0.
- Pop: `rd_en` with stored entries (written, not yet read) reads at `rd_ptr`; `rd_data`/`rd_valid` are valid the next cycle. `rd_en` with no stored entries is ignored, and `rd_valid` stays low. Pointers wrap modulo 2^RAM_AW.
- Same-cycle S3 write and pop at different addresses are both performed. Popping the entry written in the same cycle is impossible, because an entry counts as stored only after it is written.
- Reset (asserted at any time, including mid-pipeline): in-flight operations are discarded. `in_ready`=1, `result`=0, `result_valid`=0, `rd_data`=0, `rd_valid`=0, `count`=0, acc=0, and both pointers are 0. RAM contents are don't-care.

## Timing
- Throughput: 1 operation per cycle while `in_ready`=1.
- Latency: accept at edge T gives `result_valid` high for exactly the cycle after edge T+3, and the RAM entry is written at edge T+3.
- `in_ready` is combinational on `count` only; it does not depend on `in_valid` or `rd_en`.
- Pop latency: 1 cycle, rd_en sampled at edge T gives rd_data/rd_valid after edge T+1.
- Back-to-back mode-1 operations chain through the accumulator with no bubble.

## Configuration
- `ROM_MULT_SATURATE_EN`: when defined, mode-1 accumulation saturates at 2^RES_W−1 and the accumulator holds that value. When undefined, accumulation wraps modulo 2^RES_W. Mode 0 is unaffected.

## Test plan
- Multiply: after reset, issue addr1=1, addr2=2, mode 0. Required: `result`=0x0A, with `result_valid` 3 cycles after accept. A subsequent pop gives `rd_data`=0x0A.
- Accumulate: with `clr_acc` pulsed, issue back-to-back (3,4) then (5,6), mode 1. Required: results 0x24 then 0x72 on consecutive cycles.
- Wrap/saturate: issue (7,7) three times, mode 1, from acc 0. Required: results 0x78, 0xF0, 0x68 without the macro; 0x78, 0xF0, 0xFF with `ROM_MULT_SATURATE_EN`.
- Full: issue 8 accepts with no pops. Required: `count`=8 and `in_ready`=0 after the 8th accept, with further `in_valid` ignored. One pop restores `in_ready`=1 the next cycle. Drain order matches issue order.
- Empty/simultaneous: `rd_en` when empty gives no `rd_valid` and leaves `count` unchanged. An accept and a pop in the same cycle leave `count` unchanged.
- Reset mid-operation: assert `reset` low one cycle after an accept. Required: no `result_valid`, `count`=0, and all outputs at their reset values until release.
